// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: request/grant and count-write bundle between a DMA client and the arbiter
interface dma_priority_arbiter_if #(parameter int CNT_W = 16) ();
  logic [3:0]       i_dreq;
  logic [3:0]       i_mask;
  logic             i_rot_pri;
  logic             i_hlda;
  logic             i_cnt_wr;
  logic [1:0]       i_cnt_sel;
  logic [CNT_W-1:0] i_cnt_data;
  logic             o_hrq;
  logic [3:0]       o_dack;
  logic [1:0]       o_grant_ch;
  logic             o_xfer_stb;
  logic             o_tc;
  logic [3:0]       o_tc_flag;
  logic             o_busy;
  modport slave (
    input  i_dreq, i_mask, i_rot_pri, i_hlda, i_cnt_wr, i_cnt_sel, i_cnt_data,
    output o_hrq, o_dack, o_grant_ch, o_xfer_stb, o_tc, o_tc_flag, o_busy
  );
  modport master (
    output i_dreq, i_mask, i_rot_pri, i_hlda, i_cnt_wr, i_cnt_sel, i_cnt_data,
    input  o_hrq, o_dack, o_grant_ch, o_xfer_stb, o_tc, o_tc_flag, o_busy
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 4-channel single-transfer DMA arbiter with fixed/rotating priority and terminal counts
module dma_priority_arbiter #(parameter int CNT_W = 16) (
  input logic                 clk,
  input logic                 rst,
  dma_priority_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HREQ  = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;
  logic [2:0]       r_state, w_next;
  logic [1:0]       r_grant, r_rp, w_base, w_win;
  logic [3:0]       r_tc_flag, w_pend;
  logic [CNT_W-1:0] r_cnt [4];
  logic             w_xfer, w_hit, w_tc;
  assign w_pend = bus.i_dreq & ~bus.i_mask & ~r_tc_flag;
  assign w_base = bus.i_rot_pri ? r_rp : 2'd0;
  assign w_xfer = r_state == S_XFER;
  assign w_hit  = bus.i_cnt_wr && bus.i_cnt_sel == r_grant;
  assign w_tc   = w_xfer && r_cnt[r_grant] == '0 && !w_hit;
  // descending scan so the first pending channel at or after w_base wins
  always_comb begin
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (w_pend[w_base + 2'(k)]) w_win = w_base + 2'(k);
  end
  always_comb begin
    w_next = r_state == S_IDLE  ? (|w_pend ? S_HREQ : S_IDLE) :
             r_state == S_HREQ  ? (!bus.i_hlda ? S_HREQ : |w_pend ? S_GRANT : S_REL) :
             r_state == S_GRANT ? (bus.i_hlda ? S_XFER : S_REL) :
             r_state == S_XFER  ? S_REL :
             r_state == S_REL   ? (bus.i_hlda ? S_REL : S_IDLE) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'd0;
      r_rp      <= 2'd0;
      r_tc_flag <= 4'd0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_HREQ && bus.i_hlda && |w_pend) r_grant <= w_win;
      if (w_xfer) begin
        r_rp <= r_grant + 2'd1;
        if (!w_hit) r_cnt[r_grant] <= r_cnt[r_grant] - 1'b1;
        if (w_tc) r_tc_flag[r_grant] <= 1'b1;
      end
      if (bus.i_cnt_wr) begin
        r_cnt[bus.i_cnt_sel]     <= bus.i_cnt_data;
        r_tc_flag[bus.i_cnt_sel] <= 1'b0;
      end
    end
  end
  assign bus.o_hrq      = r_state == S_HREQ || r_state == S_GRANT || w_xfer;
  assign bus.o_dack     = (r_state == S_GRANT || w_xfer) ? 4'b0001 << r_grant : 4'd0;
  assign bus.o_grant_ch = r_grant;
  assign bus.o_xfer_stb = w_xfer;
  assign bus.o_tc       = w_tc;
  assign bus.o_tc_flag  = r_tc_flag;
  assign bus.o_busy     = r_state != S_IDLE;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed checks of priority, terminal count, abort, write collision and reset
module tb_dma_priority_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_hlda = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] ch;
  logic t;
  int hits;
  always #5 clk = ~clk;
  dma_priority_arbiter_if #(.CNT_W(16)) bus ();
  dma_priority_arbiter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always @(negedge clk) if (auto_hlda) bus.i_hlda = bus.o_hrq;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] s, input logic [15:0] d);
    @(negedge clk);
    bus.i_cnt_wr = 1'b1;
    bus.i_cnt_sel = s;
    bus.i_cnt_data = d;
    @(negedge clk);
    bus.i_cnt_wr = 1'b0;
  endtask
  task automatic wait_xfer(input string tag, output logic [1:0] c, output logic tcv, output logic [3:0] dk);
    logic ok;
    ok = 1'b0; c = 2'd0; tcv = 1'b0; dk = 4'd0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.o_xfer_stb) begin
        ok = 1'b1; c = bus.o_grant_ch; tcv = bus.o_tc; dk = bus.o_dack;
      end
    end
    chk({tag, "_seen"}, 32'(ok), 1);
  endtask
  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !bus.o_busy;
    end
    chk({tag, "_idle"}, 32'(ok), 1);
  endtask
  initial begin
    logic [3:0] dk;
    bus.i_dreq = 4'd0; bus.i_mask = 4'd0; bus.i_rot_pri = 1'b0; bus.i_hlda = 1'b0;
    bus.i_cnt_wr = 1'b0; bus.i_cnt_sel = 2'd0; bus.i_cnt_data = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.i_dreq = 4'b0001;
    chk("rst_hrq", 32'(bus.o_hrq), 0);
    chk("rst_dack", 32'(bus.o_dack), 0);
    chk("rst_grant", 32'(bus.o_grant_ch), 0);
    chk("rst_xfer", 32'(bus.o_xfer_stb), 0);
    chk("rst_tc", 32'(bus.o_tc), 0);
    chk("rst_flag", 32'(bus.o_tc_flag), 0);
    @(posedge clk); #1;
    chk("rst_busy", 32'(bus.o_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_dreq = 4'd0;
    #1;
    chk("rel_busy", 32'(bus.o_busy), 0);
    chk("rel_hrq", 32'(bus.o_hrq), 0);
    auto_hlda = 1'b1;
    for (int k = 0; k < 4; k++) wr(2'(k), 16'd5);
    @(negedge clk);
    bus.i_dreq = 4'b1010;
    wait_xfer("fix1", ch, t, dk);
    chk("fix1_ch", 32'(ch), 1);
    chk("fix1_dack", 32'(dk), 4'b0010);
    @(posedge clk); #1;
    chk("fix1_single", 32'(bus.o_xfer_stb), 0);
    chk("fix1_rel_hrq", 32'(bus.o_hrq), 0);
    wait_xfer("fix2", ch, t, dk);
    chk("fix2_ch", 32'(ch), 1);
    @(negedge clk);
    bus.i_dreq = 4'd0;
    wait_idle("fix2");
    chk("fix_cnt1", 32'(dut.r_cnt[1]), 3);
    @(negedge clk);
    bus.i_dreq = 4'b1010;
    bus.i_mask = 4'b0010;
    wait_xfer("mask", ch, t, dk);
    chk("mask_ch", 32'(ch), 3);
    @(negedge clk);
    bus.i_dreq = 4'd0;
    bus.i_mask = 4'd0;
    wait_idle("mask");
    @(negedge clk);
    bus.i_rot_pri = 1'b1;
    bus.i_dreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_xfer("rot", ch, t, dk);
      chk($sformatf("rot%0d_ch", k), 32'(ch), 32'(k % 4));
    end
    @(negedge clk);
    bus.i_dreq = 4'd0;
    bus.i_rot_pri = 1'b0;
    wait_idle("rot");
    wr(2'd2, 16'd1);
    @(negedge clk);
    bus.i_dreq = 4'b0100;
    wait_xfer("tc1", ch, t, dk);
    chk("tc1_ch", 32'(ch), 2);
    chk("tc1_tc", 32'(t), 0);
    wait_xfer("tc2", ch, t, dk);
    chk("tc2_ch", 32'(ch), 2);
    chk("tc2_tc", 32'(t), 1);
    wait_idle("tc2");
    chk("tc_flag", 32'(bus.o_tc_flag), 4'b0100);
    chk("tc_wrap", 32'(dut.r_cnt[2]), 16'hFFFF);
    hits = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_hrq) hits++;
    end
    chk("tc_no_hrq", 32'(hits), 0);
    wr(2'd2, 16'd3);
    chk("tc_flag_clr", 32'(bus.o_tc_flag), 0);
    wait_xfer("tc3", ch, t, dk);
    chk("tc3_ch", 32'(ch), 2);
    @(negedge clk);
    bus.i_dreq = 4'd0;
    wait_idle("tc3");
    wr(2'd0, 16'd9);
    auto_hlda = 1'b0;
    @(negedge clk);
    bus.i_hlda = 1'b0;
    bus.i_dreq = 4'b0001;
    @(posedge clk); #1;
    chk("ab_hreq", 32'(bus.o_hrq), 1);
    @(negedge clk);
    bus.i_hlda = 1'b1;
    @(posedge clk); #1;
    chk("ab_dack", 32'(bus.o_dack), 4'b0001);
    @(negedge clk);
    bus.i_hlda = 1'b0;
    bus.i_dreq = 4'd0;
    @(posedge clk); #1;
    chk("ab_hrq", 32'(bus.o_hrq), 0);
    chk("ab_rel_dack", 32'(bus.o_dack), 0);
    chk("ab_xfer", 32'(bus.o_xfer_stb), 0);
    chk("ab_cnt", 32'(dut.r_cnt[0]), 9);
    wait_idle("ab");
    auto_hlda = 1'b1;
    wr(2'd1, 16'd0);
    @(negedge clk);
    bus.i_dreq = 4'b0010;
    wait_xfer("col", ch, t, dk);
    @(negedge clk);
    bus.i_cnt_wr = 1'b1;
    bus.i_cnt_sel = 2'd1;
    bus.i_cnt_data = 16'd7;
    bus.i_dreq = 4'd0;
    #1;
    chk("col_xfer", 32'(bus.o_xfer_stb), 1);
    chk("col_tc", 32'(bus.o_tc), 0);
    @(negedge clk);
    bus.i_cnt_wr = 1'b0;
    chk("col_cnt", 32'(dut.r_cnt[1]), 7);
    chk("col_flag", 32'(bus.o_tc_flag), 0);
    wait_idle("col");
    @(negedge clk);
    bus.i_dreq = 4'b1000;
    wait_xfer("rx", ch, t, dk);
    #1;
    rst = 1'b1;
    #1;
    chk("rx_hrq", 32'(bus.o_hrq), 0);
    chk("rx_dack", 32'(bus.o_dack), 0);
    chk("rx_xfer", 32'(bus.o_xfer_stb), 0);
    chk("rx_busy", 32'(bus.o_busy), 0);
    chk("rx_grant", 32'(bus.o_grant_ch), 0);
    chk("rx_cnt", 32'(dut.r_cnt[3]), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_rel_busy", 32'(bus.o_busy), 0);
    wait_xfer("rx2", ch, t, dk);
    chk("rx2_ch", 32'(ch), 3);
    chk("rx2_tc", 32'(t), 1);
    @(negedge clk);
    bus.i_dreq = 4'd0;
    wait_idle("rx2");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
